// File: rtl/tod_clock_core.sv
// Time-of-day clock: prescaled 24 h binary counter with preset load, alarm comparator
// and registered 12 h/24 h BCD display.
module tod_clock_core #(
  parameter int unsigned TICK_DIV         = 100000000,
  parameter bit          ALARM_EN_DEFAULT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       run,
  input  logic       mode_12h,
  input  logic [4:0] inhrs,
  input  logic [5:0] inmin,
  input  logic [5:0] insec,
  input  logic       alarm_set,
  input  logic       alarm_clr,
  input  logic [4:0] alarm_hrs,
  input  logic [5:0] alarm_min,
  output logic [3:0] outhrstens,
  output logic [3:0] outhrsones,
  output logic [3:0] outmintens,
  output logic [3:0] outminones,
  output logic [3:0] outsectens,
  output logic [3:0] outsecones,
  output logic       pm,
  output logic       sec_pulse,
  output logic       alarm_hit
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PrescMax = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q;
  logic [4:0]    hrs_q, al_hrs_q;
  logic [5:0]    min_q, sec_q, al_min_q;
  logic          armed_q;
  logic          tick_q, hit_q;

  logic          tick, match;
  logic [4:0]    hrs_inc, hrs_sat, disp_hrs;
  logic [5:0]    min_inc, sec_inc, min_sat, sec_sat;
  logic [7:0]    hrs_bcd, min_bcd, sec_bcd;

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] rem;
    tens = '0;
    rem  = v;
    for (int i = 0; i < 6; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  assign tick = run & ~load & (presc_q == PrescMax);

  always_comb begin
    hrs_inc = hrs_q;
    min_inc = min_q;
    sec_inc = sec_q + 6'd1;
    if (sec_q == 6'd59) begin
      sec_inc = '0;
      min_inc = min_q + 6'd1;
      if (min_q == 6'd59) begin
        min_inc = '0;
        hrs_inc = (hrs_q == 5'd23) ? 5'd0 : hrs_q + 5'd1;
      end
    end
  end

  assign hrs_sat = (inhrs > 5'd23) ? 5'd23 : inhrs;
  assign min_sat = (inmin > 6'd59) ? 6'd59 : inmin;
  assign sec_sat = (insec > 6'd59) ? 6'd59 : insec;

  // Compared against the post-increment time so the strobe lines up with the new digits.
  assign match = armed_q && (hrs_inc == al_hrs_q) && (min_inc == al_min_q) && (sec_inc == 6'd0);

  always_comb begin
    disp_hrs = hrs_q;
    if (mode_12h) begin
      if (hrs_q == 5'd0) begin
        disp_hrs = 5'd12;
      end else if (hrs_q > 5'd12) begin
        disp_hrs = hrs_q - 5'd12;
      end
    end
  end

  assign hrs_bcd = to_bcd({1'b0, disp_hrs});
  assign min_bcd = to_bcd(min_q);
  assign sec_bcd = to_bcd(sec_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q  <= '0;
      hrs_q    <= '0;
      min_q    <= '0;
      sec_q    <= '0;
      armed_q  <= ALARM_EN_DEFAULT;
      al_hrs_q <= '0;
      al_min_q <= '0;
      tick_q   <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      if (load) begin
        presc_q <= '0;
        hrs_q   <= hrs_sat;
        min_q   <= min_sat;
        sec_q   <= sec_sat;
      end else if (run) begin
        presc_q <= tick ? '0 : presc_q + PW'(1);
        if (tick) begin
          hrs_q <= hrs_inc;
          min_q <= min_inc;
          sec_q <= sec_inc;
        end
      end
      if (alarm_clr) begin
        armed_q <= 1'b0;
      end else if (alarm_set) begin
        armed_q  <= 1'b1;
        al_hrs_q <= alarm_hrs;
        al_min_q <= alarm_min;
      end
      tick_q <= tick;
      hit_q  <= tick & match;
    end
  end

  // Display stage: one cycle behind the time registers; strobes delayed to match.
  always_ff @(posedge clk) begin
    if (reset) begin
      outhrstens <= '0;
      outhrsones <= '0;
      outmintens <= '0;
      outminones <= '0;
      outsectens <= '0;
      outsecones <= '0;
      pm         <= 1'b0;
      sec_pulse  <= 1'b0;
      alarm_hit  <= 1'b0;
    end else begin
      {outhrstens, outhrsones} <= hrs_bcd;
      {outmintens, outminones} <= min_bcd;
      {outsectens, outsecones} <= sec_bcd;
      pm         <= mode_12h & (hrs_q >= 5'd12);
      sec_pulse  <= tick_q & ~load;
      alarm_hit  <= hit_q & ~load;
    end
  end

endmodule
